dmem_arbiter: RTL

//  Two-requester arbiter/sequencer in front of the block-wide data memory. Accepts read/write

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of every non-clock/reset signal of dmem_arbiter: the two requester
// ports, their shared response data, the halt request and the memory-side bus.
//  slave  modport : used by the arbiter itself
//  master modport : used by whoever drives requests and models the memory
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 128
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [BLK_W-1:0]  req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [BLK_W-1:0]  req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [BLK_W-1:0]  rsp_data1;
    logic [BLK_W-1:0]  rsp_data2;
    logic              halt_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic              mem_readable;
    logic              mem_writable;
    logic [BLK_W-1:0]  mem_out1;
    logic [BLK_W-1:0]  mem_out2;
    logic              mem_flush;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  halt_req, mem_out1, mem_out2,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_data1, rsp_data2,
        output mem_addr, mem_wdata, mem_readable, mem_writable, mem_flush
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output halt_req, mem_out1, mem_out2,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_data1, rsp_data2,
        input  mem_addr, mem_wdata, mem_readable, mem_writable, mem_flush
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the block data memory.
// One access at a time: IDLE (grant) -> SETUP (address out, strobes low) ->
// STROBE (level strobe held MEM_LAT cycles) -> RESP (completion pulse) -> IDLE.
// A halt request parks the block in HALT with the flush strobe held until reset.
// Ports:
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  bus   : dmem_arbiter_if.slave (requests, responses, halt, memory bus)
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLK_W   = 128,
    parameter int MEM_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_RESP   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic              halt_pend_q, halt_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BLK_W-1:0]  wdata_q, wdata_d;
    logic [BLK_W-1:0]  data1_q, data1_d;
    logic [BLK_W-1:0]  data2_q, data2_d;

    logic              halt_now_s;
    logic              gnt_v_s;
    logic              gnt_port_s;

    // A halt seen during an access is remembered so it wins in the next IDLE.
    assign halt_now_s = bus.halt_req | halt_pend_q;
    assign gnt_v_s    = (state_q == ST_IDLE) & ~halt_now_s & (bus.req0_valid | bus.req1_valid);
    // On a tie the port that did not win last time is granted.
    assign gnt_port_s = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;

    assign bus.req0_ready   = gnt_v_s & ~gnt_port_s;
    assign bus.req1_ready   = gnt_v_s &  gnt_port_s;
    assign bus.rsp0_valid   = (state_q == ST_RESP) & ~port_q;
    assign bus.rsp1_valid   = (state_q == ST_RESP) &  port_q;
    assign bus.rsp_data1    = data1_q;
    assign bus.rsp_data2    = data2_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_readable = (state_q == ST_STROBE) & ~we_q;
    assign bus.mem_writable = (state_q == ST_STROBE) &  we_q;
    // Flush rises in the very IDLE cycle the halt is taken, then stays high in HALT.
    assign bus.mem_flush    = (state_q == ST_HALT) | ((state_q == ST_IDLE) & halt_now_s);

    // Next-state and datapath-latch logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        port_d      = port_q;
        last_d      = last_q;
        halt_pend_d = halt_pend_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        if ((state_q != ST_IDLE) && (state_q != ST_HALT) && bus.halt_req) begin
            halt_pend_d = 1'b1;
        end else begin
            halt_pend_d = halt_pend_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (halt_now_s) begin
                    state_d = ST_HALT;
                end else if (gnt_v_s) begin
                    state_d = ST_SETUP;
                    port_d  = gnt_port_s;
                    last_d  = gnt_port_s;
                    we_d    = gnt_port_s ? bus.req1_we    : bus.req0_we;
                    addr_d  = gnt_port_s ? bus.req1_addr  : bus.req0_addr;
                    wdata_d = gnt_port_s ? bus.req1_wdata : bus.req0_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = 4'(MEM_LAT - 1);
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        data1_d = bus.mem_out1;
                        data2_d = bus.mem_out2;
                    end else begin
                        data1_d = data1_q;
                        data2_d = data2_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers; reset restores port-0 preference on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            port_q      <= 1'b0;
            last_q      <= 1'b1;
            halt_pend_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            port_q      <= port_d;
            last_q      <= last_d;
            halt_pend_q <= halt_pend_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
        end
    end
endmodule
